// File: rtl/fazyrv_membus_arb_if.sv
// Bundle of requester (imem/dmem) and shared memory port signals for the FazyRV bus arbiter.
// The arbiter uses the master modport; the surrounding core/memory uses slave.
interface fazyrv_membus_arb_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic          imem_stb_i;
    logic [AW-1:0] imem_adr_i;
    logic          imem_ack_o;
    logic [DW-1:0] imem_rdat_o;

    logic          dmem_stb_i;
    logic          dmem_we_i;
    logic [BW-1:0] dmem_be_i;
    logic [AW-1:0] dmem_adr_i;
    logic [DW-1:0] dmem_wdat_i;
    logic          dmem_ack_o;
    logic [DW-1:0] dmem_rdat_o;

    logic          mem_stb_o;
    logic          mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_wdat_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdat_i;

    logic          err_o;

    modport master (
        input  imem_stb_i, imem_adr_i,
        input  dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_wdat_i,
        input  mem_ack_i, mem_rdat_i,
        output imem_ack_o, imem_rdat_o, dmem_ack_o, dmem_rdat_o,
        output mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_wdat_o,
        output err_o
    );

    modport slave (
        output imem_stb_i, imem_adr_i,
        output dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_wdat_i,
        output mem_ack_i, mem_rdat_i,
        input  imem_ack_o, imem_rdat_o, dmem_ack_o, dmem_rdat_o,
        input  mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_wdat_o,
        input  err_o
    );
endinterface

// File: rtl/fazyrv_membus_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Optional access timeout enabled by defining FAZYRV_ARB_TIMEOUT_EN.
module fazyrv_membus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_in,
    fazyrv_membus_arb_if.master bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fazyrv_membus_arb: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: dmem was granted last
    logic   gnt_stb;
    logic   expire;
    logic   done;

`ifdef FAZYRV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_in) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_d_d         = last_d_q;
        gnt_stb          = 1'b0;
        expire           = 1'b0;
        done             = 1'b0;
        bus.mem_stb_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_be_o     = '0;
        bus.mem_adr_o    = '0;
        bus.mem_wdat_o   = '0;
        bus.imem_ack_o   = 1'b0;
        bus.dmem_ack_o   = 1'b0;
        bus.err_o        = 1'b0;
        bus.imem_rdat_o  = bus.mem_rdat_i;
        bus.dmem_rdat_o  = bus.mem_rdat_i;
`ifdef FAZYRV_ARB_TIMEOUT_EN
        cnt_d            = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // On a tie, grant whichever side did not win last time
                if (bus.dmem_stb_i && (!bus.imem_stb_i || !last_d_q)) state_d = GNT_D;
                else if (bus.imem_stb_i)                               state_d = GNT_I;
`ifdef FAZYRV_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            GNT_I: begin
                gnt_stb       = bus.imem_stb_i;
                bus.mem_adr_o = bus.imem_adr_i;
                bus.mem_be_o  = 4'hF;
            end
            GNT_D: begin
                gnt_stb        = bus.dmem_stb_i;
                bus.mem_we_o   = bus.dmem_we_i;
                bus.mem_be_o   = bus.dmem_be_i;
                bus.mem_adr_o  = bus.dmem_adr_i;
                bus.mem_wdat_o = bus.dmem_wdat_i;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == GNT_I || state_q == GNT_D) begin
`ifdef FAZYRV_ARB_TIMEOUT_EN
            expire = gnt_stb && !bus.mem_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
            if (gnt_stb && !bus.mem_ack_i) cnt_d = cnt_q + CNT_W'(1);
`endif
            done           = gnt_stb && (bus.mem_ack_i || expire);
            bus.mem_stb_o  = gnt_stb && !expire;
            bus.imem_ack_o = done && (state_q == GNT_I);
            bus.dmem_ack_o = done && (state_q == GNT_D);
            bus.err_o      = expire;
            // Withdrawal or completion both release the port next cycle
            if (!gnt_stb || done) state_d = IDLE;
            if (done)             last_d_d = (state_q == GNT_D);
        end
    end

endmodule

// File: tb/tb_fazyrv_membus_arb.sv
// Randomized and directed bench for fazyrv_membus_arb against a transaction-level ownership model.
// Honours FAZYRV_ARB_TIMEOUT_EN the same way the design does.
module tb_fazyrv_membus_arb;
    localparam int unsigned TMO = 4;
`ifdef FAZYRV_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fazyrv_membus_arb_if bus ();

    fazyrv_membus_arb #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the port (0 none, 1 imem, 2 dmem), who finished last, cycles spent unacked
    int owner      = 0;
    int last_owner = 1;
    int used       = 0;
    bit model_ok   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, compare outputs against the model, then advance the model
    task automatic cycle(input bit r, input bit is, input bit ds, input bit ma);
        logic [31:0] iadr, dadr, dwdat, rdat;
        logic [3:0]  dbe;
        logic        dwe;
        bit          s, timed_out, acked;
        logic [31:0] e_adr, e_wdat;
        logic [3:0]  e_be;
        logic        e_we;

        iadr  = $urandom;
        dadr  = $urandom;
        dwdat = $urandom;
        rdat  = $urandom;
        dbe   = 4'($urandom);
        dwe   = 1'($urandom);

        @(negedge clk);
        rst_n            = r;
        bus.imem_stb_i   = is;
        bus.imem_adr_i   = iadr;
        bus.dmem_stb_i   = ds;
        bus.dmem_we_i    = dwe;
        bus.dmem_be_i    = dbe;
        bus.dmem_adr_i   = dadr;
        bus.dmem_wdat_i  = dwdat;
        bus.mem_ack_i    = ma;
        bus.mem_rdat_i   = rdat;
        #2;

        s         = (owner == 1) ? is : (owner == 2) ? ds : 1'b0;
        timed_out = TMO_EN && s && !ma && (used + 1 == int'(TMO));
        acked     = s && (ma || timed_out);
        e_adr     = (owner == 1) ? iadr : (owner == 2) ? dadr : 32'h0;
        e_be      = (owner == 1) ? 4'hF : (owner == 2) ? dbe : 4'h0;
        e_we      = (owner == 2) ? dwe : 1'b0;
        e_wdat    = (owner == 2) ? dwdat : 32'h0;

        if (model_ok) begin
            check_eq("mem_stb",   32'(bus.mem_stb_o),  32'(s && !timed_out));
            check_eq("mem_adr",   bus.mem_adr_o,       e_adr);
            check_eq("mem_be",    32'(bus.mem_be_o),   32'(e_be));
            check_eq("mem_we",    32'(bus.mem_we_o),   32'(e_we));
            check_eq("mem_wdat",  bus.mem_wdat_o,      e_wdat);
            check_eq("imem_ack",  32'(bus.imem_ack_o), 32'(owner == 1 && acked));
            check_eq("dmem_ack",  32'(bus.dmem_ack_o), 32'(owner == 2 && acked));
            check_eq("err",       32'(bus.err_o),      32'(timed_out));
            check_eq("imem_rdat", bus.imem_rdat_o,     rdat);
            check_eq("dmem_rdat", bus.dmem_rdat_o,     rdat);
        end

        @(posedge clk);
        if (!r) begin
            owner = 0; last_owner = 1; used = 0; model_ok = 1'b1;
        end else if (owner == 0) begin
            if (is && ds)  owner = (last_owner == 1) ? 2 : 1;
            else if (ds)   owner = 2;
            else if (is)   owner = 1;
            used = 0;
        end else if (!s || acked) begin
            if (acked) last_owner = owner;
            owner = 0;
            used  = 0;
        end else begin
            used++;
        end
    endtask

    initial begin
        bit is, ds;
        rst_n           = 1'b0;
        bus.imem_stb_i  = 1'b0;
        bus.imem_adr_i  = '0;
        bus.dmem_stb_i  = 1'b0;
        bus.dmem_we_i   = 1'b0;
        bus.dmem_be_i   = '0;
        bus.dmem_adr_i  = '0;
        bus.dmem_wdat_i = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdat_i  = '0;

        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);

        // Single fetch acked on the fourth cycle
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 0, 0, 0);

        // Tie right after reset: dmem first, then an idle cycle, then imem
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 1);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 0, 0, 0);

        // Data withdrawal followed by a late ack in idle
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);

        // Fetch held with no ack for 100 cycles
        for (int i = 0; i < 100; i++) cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);

        // Reset in the middle of a granted fetch, then a fresh request
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 1);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 1);
        cycle(1, 0, 0, 0);

        // Randomized traffic with sticky requests and occasional reset
        is = 1'b0;
        ds = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            is = is ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            ds = ds ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            cycle(($urandom_range(0, 99) != 0), is, ds, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
